// File: rtl/iterative_multiplier_pkg.sv
// Shared definitions for the iterative multiplier slice.
//   REG_IDX_W   : register-file index width (destination tag)
//   DATA_W      : default datapath width
//   mul_state_e : FSM state encoding (idle / run / done)
package iterative_multiplier_pkg;

    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned DATA_W    = 32;

    typedef enum logic [1:0] {
        MulIdle = 2'd0,
        MulRun  = 2'd1,
        MulDone = 2'd2
    } mul_state_e;

endpackage

// File: rtl/iterative_multiplier_mul_step.sv
// One combinational shift-add iteration of the multiplier.
// Ports:
//   acc_i / mcand_i / mplier_i : current accumulator, multiplicand, multiplier
//   next_acc_o                 : acc + mcand when mplier[0] is set (mod 2^WIDTH)
//   next_mcand_o               : mcand shifted left by one
//   next_mplier_o              : mplier shifted right by one
module iterative_multiplier_mul_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic [WIDTH-1:0] next_acc_o,
    output logic [WIDTH-1:0] next_mcand_o,
    output logic [WIDTH-1:0] next_mplier_o
);

    always_comb begin
        next_acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
        next_mcand_o  = mcand_i << 1;
        next_mplier_o = mplier_i >> 1;
    end

endmodule

// File: rtl/iterative_multiplier.sv
// Multi-cycle shift-add unit for MUL / MLA, feeding the register-file write port.
// Ports:
//   CLK, RESET           : rising-edge clock, synchronous active-high reset
//   Start                : request, sampled only while idle
//   MulA, MulB, AccIn    : multiplicand, multiplier, accumulate operand
//   AccEn                : 1 = MLA (A*B+Acc), 0 = MUL
//   DestIn               : destination register index, latched with Start
//   Busy                 : high while running or finishing
//   Done, WE             : one-cycle result-valid / write-enable pulse
//   DestOut, Result      : latched destination index and product
//   FlagN, FlagZ         : sign and zero of Result, updated with Done
// Build option: MUL_EARLY_TERM_EN ends the run as soon as the remaining
// multiplier bits are all zero; results are identical either way.
module iterative_multiplier
    import iterative_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     MulA,
    input  logic [WIDTH-1:0]     MulB,
    input  logic [WIDTH-1:0]     AccIn,
    input  logic                 AccEn,
    input  logic [REG_IDX_W-1:0] DestIn,
    output logic                 Busy,
    output logic                 Done,
    output logic                 WE,
    output logic [REG_IDX_W-1:0] DestOut,
    output logic [WIDTH-1:0]     Result,
    output logic                 FlagN,
    output logic                 FlagZ
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    mul_state_e state_q, state_d;

    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [REG_IDX_W-1:0] dest_q, dest_d;
    logic                 done_q, done_d;
    logic                 flag_n_q, flag_n_d;
    logic                 flag_z_q, flag_z_d;

    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_mcand;
    logic [WIDTH-1:0] step_mplier;

    iterative_multiplier_mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i         (acc_q),
        .mcand_i       (mcand_q),
        .mplier_i      (mplier_q),
        .next_acc_o    (step_acc),
        .next_mcand_o  (step_mcand),
        .next_mplier_o (step_mplier)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        dest_d   = dest_q;
        done_d   = 1'b0;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;

        case (state_q)
            MulIdle: begin
                if (Start) begin
                    mcand_d  = MulA;
                    mplier_d = MulB;
                    acc_d    = AccEn ? AccIn : '0;
                    dest_d   = DestIn;
                    count_d  = '0;
                    state_d  = MulRun;
                end
            end
            MulRun: begin
`ifdef MUL_EARLY_TERM_EN
                // No set bits left: further iterations cannot change acc.
                if (mplier_q == '0) begin
                    state_d = MulDone;
                end else begin
                    acc_d    = step_acc;
                    mcand_d  = step_mcand;
                    mplier_d = step_mplier;
                    count_d  = count_q + CntW'(1);
                    if (count_q == LastCnt) begin
                        state_d = MulDone;
                    end
                end
`else
                acc_d    = step_acc;
                mcand_d  = step_mcand;
                mplier_d = step_mplier;
                count_d  = count_q + CntW'(1);
                if (count_q == LastCnt) begin
                    state_d = MulDone;
                end
`endif
            end
            MulDone: begin
                // Outputs are registered, so the pulse appears in the following idle cycle.
                done_d   = 1'b1;
                result_d = acc_q;
                flag_n_d = acc_q[WIDTH-1];
                flag_z_d = (acc_q == '0);
                state_d  = MulIdle;
            end
            default: begin
                state_d = MulIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= MulIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            dest_q   <= '0;
            done_q   <= 1'b0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            dest_q   <= dest_d;
            done_q   <= done_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign Busy    = (state_q != MulIdle);
    assign Done    = done_q;
    assign WE      = done_q;
    assign DestOut = dest_q;
    assign Result  = result_q;
    assign FlagN   = flag_n_q;
    assign FlagZ   = flag_z_q;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Self-checking bench for iterative_multiplier: a driver issues MUL/MLA ops and
// pushes expected results into a scoreboard; a monitor pops and compares on WE.
module tb_iterative_multiplier;

    localparam int unsigned W = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          Start;
    logic [W-1:0]  MulA, MulB, AccIn;
    logic          AccEn;
    logic [3:0]    DestIn;
    logic          Busy, Done, WE;
    logic [3:0]    DestOut;
    logic [W-1:0]  Result;
    logic          FlagN, FlagZ;

    iterative_multiplier #(
        .WIDTH (W)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .Start   (Start),
        .MulA    (MulA),
        .MulB    (MulB),
        .AccIn   (AccIn),
        .AccEn   (AccEn),
        .DestIn  (DestIn),
        .Busy    (Busy),
        .Done    (Done),
        .WE      (WE),
        .DestOut (DestOut),
        .Result  (Result),
        .FlagN   (FlagN),
        .FlagZ   (FlagZ)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   dest;
        int unsigned  due;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_res = '0;
    logic [3:0]   last_dest = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Cycles from the Start-sampling edge to the edge that raises Done.
    function automatic int unsigned lat_of(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        int h = -1;
        for (int i = 0; i < int'(W); i++) if (b[i]) h = i;
        if (h < 0) return 2;
        if (h + 3 > int'(W) + 1) return W + 1;
        return h + 3;
`else
        return W + 1;
`endif
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] acc, input logic en);
        longint unsigned p;
        p = longint'(a) * longint'(b) + (en ? longint'(acc) : 64'd0);
        return p[W-1:0];
    endfunction

    // Monitor
    always @(negedge CLK) begin
        if (RESET === 1'b0 && WE === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_we", {63'd0, WE}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 64'(Result), 64'(e.res));
                check("dest", 64'(DestOut), 64'(e.dest));
                check("flag_n", 64'(FlagN), 64'(e.res[W-1]));
                check("flag_z", 64'(FlagZ), 64'(e.res == '0));
                check("done_eq_we", 64'(Done), 64'd1);
                check("busy_at_done", 64'(Busy), 64'd0);
                check("latency_cycle", 64'(cyc), 64'(e.due));
                last_res  = e.res;
                last_dest = e.dest;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (Busy !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (Busy !== 1'b0) check("idle_timeout", 64'(Busy), 64'd0);
    endtask

    // Called at a negedge; the op is sampled at the next posedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] acc,
                         input logic en, input logic [3:0] dest, output int unsigned due);
        exp_t e;
        wait_idle();
        MulA   = a;
        MulB   = b;
        AccIn  = acc;
        AccEn  = en;
        DestIn = dest;
        Start  = 1'b1;
        e.res  = model(a, b, acc, en);
        e.dest = dest;
        e.due  = cyc + 1 + lat_of(b);
        due    = e.due;
        sb.push_back(e);
        @(negedge CLK);
        Start  = 1'b0;
        // Operand changes after sampling must not matter.
        MulA   = $urandom;
        MulB   = $urandom;
        AccIn  = $urandom;
        AccEn  = 1'($urandom);
        DestIn = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_result_hold"}, 64'(Result), 64'(last_res));
        check({tag, "_dest_hold"}, 64'(DestOut), 64'(last_dest));
        check({tag, "_we_idle"}, 64'(WE), 64'd0);
    endtask

    initial begin
        int unsigned due;
        logic [W-1:0] b;

        RESET  = 1'b1;
        Start  = 1'b0;
        MulA   = '0;
        MulB   = '0;
        AccIn  = '0;
        AccEn  = 1'b0;
        DestIn = '0;
        repeat (3) @(negedge CLK);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_we", 64'(WE), 64'd0);
        check("rst_result", 64'(Result), 64'd0);
        check("rst_dest", 64'(DestOut), 64'd0);
        check("rst_flags", {62'd0, FlagN, FlagZ}, 64'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Directed: MUL, negative product, MLA to zero.
        issue(32'd7, 32'd6, 32'd0, 1'b0, 4'd3, due);
        drain();
        check_hold("mul7x6");
        issue(32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 4'd9, due);
        drain();
        issue(32'd5, 32'd5, 32'hFFFF_FFE7, 1'b1, 4'd1, due);
        drain();
        check("mla_zero_flag", 64'(FlagZ), 64'd1);

        // Extra Start pulses mid-run and in the finishing cycle are ignored;
        // the following op is accepted in the Done cycle.
        issue($urandom | 32'h8000_0000, 32'h8000_0001 | $urandom, $urandom, 1'b1, 4'd5, due);
        repeat (3) @(negedge CLK);
        MulA  = 32'd1;
        MulB  = 32'd1;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        while (cyc + 1 < due) @(negedge CLK);
        Start = 1'b1;
        @(negedge CLK);
        issue(32'd11, 32'd13, 32'd100, 1'b1, 4'd7, due);
        drain();
        check_hold("after_ignored_start");

        // Reset mid-run aborts with no write.
        issue($urandom, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd12, due);
        repeat (9) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        sb.delete();
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_we", 64'(WE), 64'd0);
        check("abort_result", 64'(Result), 64'd0);
        check("abort_dest", 64'(DestOut), 64'd0);
        RESET     = 1'b0;
        last_res  = '0;
        last_dest = '0;
        repeat (3) @(negedge CLK);
        check_hold("after_abort");

        // Short multipliers (early-termination latencies when enabled).
        issue(32'h1234_5678, 32'd0, 32'd0, 1'b0, 4'd2, due);
        issue(32'd9, 32'd3, 32'd0, 1'b0, 4'd4, due);
        drain();

        // Randomized ops, issued back to back.
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0:       b = $urandom_range(0, 255);
                1:       b = $urandom & 32'h0000_FFFF;
                default: b = $urandom;
            endcase
            issue($urandom, b, $urandom, 1'($urandom), 4'($urandom), due);
        end
        drain();
        check_hold("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
